hazard_scoreboard: RTL and testbench

Parametrised data-hazard unit for the in-order NPC pipeline, sitting beside the IDU. Each cycle it:
- generates per-read-port forwarding selects from any number of downstream stages;
- raises load-use stalls;
- tracks registers owned by the variable-latency multiply/divide unit (MDU) in a busy scoreboard.

It also keeps a stall-cycle counter and a sticky protocol-error flag for debug.

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit beside the IDU: per-port forwarding selects, load-use and
// MDU scoreboard stalls, plus a saturating stall counter and a sticky error flag.
module hazard_scoreboard #(
  parameter  int AW       = 5,
  parameter  int NRP      = 2,
  parameter  int NSTG     = 3,
  parameter  int LD_STG   = 2,
  parameter  int MAX_PEND = 2,
  parameter  int CNTW     = 32,
  localparam int SW       = $clog2(NSTG + 1),
  localparam int NREG     = 2 ** AW,
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  input  logic [NRP*AW-1:0]   id_rs_i,
  input  logic [NRP-1:0]      id_rs_use_i,
  input  logic [AW-1:0]       id_rd_i,
  input  logic                id_wen_i,
  input  logic                id_mdu_i,
  input  logic                id_fire_i,
  input  logic [NSTG*AW-1:0]  stg_rd_i,
  input  logic [NSTG-1:0]     stg_wen_i,
  input  logic [NSTG-1:0]     stg_ld_i,
  input  logic                mdu_done_i,
  input  logic [AW-1:0]       mdu_done_rd_i,
  input  logic                flush_i,
  output logic [NRP*SW-1:0]   fwd_sel_o,
  output logic                stall_o,
  output logic [NREG-1:0]     busy_o,
  output logic [PW-1:0]       pend_cnt_o,
  output logic [CNTW-1:0]     stall_cnt_o,
  output logic                sb_err_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            err_q, err_d;

  logic [NRP-1:0]  lu_vec;
  logic [NRP-1:0]  raw_vec;
  logic            waw_hz, cap_hz, pend_full;
  logic            issue_req, issue_ok, done_ok;

  for (genvar gi = 0; gi < NRP; gi++) begin : g_port
    logic [AW-1:0] rs;
    logic [SW-1:0] sel;
    logic          ld;

    assign rs = id_rs_i[gi*AW +: AW];

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
      sel = '0;
      ld  = 1'b0;
      for (int s = NSTG - 1; s >= 0; s--) begin
        if (id_rs_use_i[gi] && stg_wen_i[s] && (stg_rd_i[s*AW +: AW] == rs) && (rs != '0)) begin
          sel = SW'(s + 1);
          ld  = stg_ld_i[s] && (s < LD_STG);
        end
      end
    end

    assign fwd_sel_o[gi*SW +: SW] = sel;
    assign lu_vec[gi]  = ld;
    assign raw_vec[gi] = id_rs_use_i[gi] && (rs != '0) && busy_q[rs];
  end

  assign pend_full = (pend_q == PW'(MAX_PEND));
  assign waw_hz    = id_wen_i && (id_rd_i != '0) && busy_q[id_rd_i];
  assign cap_hz    = id_mdu_i && pend_full;
  assign stall_o   = id_valid_i && ((|lu_vec) || (|raw_vec) || waw_hz || cap_hz);

  assign issue_req = id_fire_i && id_mdu_i && id_wen_i && (id_rd_i != '0);
  assign done_ok   = mdu_done_i && busy_q[mdu_done_rd_i];
  // A concurrent completion frees a slot, so a full scoreboard can still accept.
  assign issue_ok  = issue_req && !stall_o && !(pend_full && !done_ok);

  always_comb begin
    busy_d      = busy_q;
    pend_d      = pend_q + PW'(issue_ok) - PW'(done_ok);
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    if (done_ok)  busy_d[mdu_done_rd_i] = 1'b0;
    if (issue_ok) busy_d[id_rd_i] = 1'b1;
    if (flush_i) begin
      busy_d = '0;
      pend_d = '0;
    end

    if ((mdu_done_i && !done_ok) || (id_fire_i && stall_o) ||
        (issue_req && !stall_o && pend_full && !done_ok))
      err_d = 1'b1;

    if (id_valid_i && stall_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign pend_cnt_o  = pend_q;
  assign stall_cnt_o = stall_cnt_q;
  assign sb_err_o    = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed test-plan scenarios then
// random traffic, all predicted by a set-based reference model.
module tb_hazard_scoreboard;
  localparam int AW = 5, NRP = 2, NSTG = 3, LD_STG = 2, MAX_PEND = 2, CNTW = 32;
  localparam int SW = $clog2(NSTG + 1), NREG = 2 ** AW, PW = $clog2(MAX_PEND + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_wen, id_mdu, id_fire, mdu_done, flush;
  logic [NRP*AW-1:0]  id_rs;
  logic [NRP-1:0]     id_rs_use;
  logic [AW-1:0]      id_rd, mdu_done_rd;
  logic [NSTG*AW-1:0] stg_rd;
  logic [NSTG-1:0]    stg_wen, stg_ld;
  logic [NRP*SW-1:0]  fwd_sel;
  logic               stall, sb_err;
  logic [NREG-1:0]    busy;
  logic [PW-1:0]      pend_cnt;
  logic [CNTW-1:0]    stall_cnt;

  hazard_scoreboard #(.AW(AW), .NRP(NRP), .NSTG(NSTG), .LD_STG(LD_STG),
                      .MAX_PEND(MAX_PEND), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_use_i(id_rs_use), .id_rd_i(id_rd), .id_wen_i(id_wen), .id_mdu_i(id_mdu),
    .id_fire_i(id_fire), .stg_rd_i(stg_rd), .stg_wen_i(stg_wen), .stg_ld_i(stg_ld),
    .mdu_done_i(mdu_done), .mdu_done_rd_i(mdu_done_rd), .flush_i(flush),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .busy_o(busy), .pend_cnt_o(pend_cnt),
    .stall_cnt_o(stall_cnt), .sb_err_o(sb_err));

  always #5 clk = ~clk;

  typedef struct {
    longint sel; longint stl; longint bsy; longint pend; longint scnt; longint err;
  } exp_t;
  exp_t expq[$];

  int n_pass = 0, n_total = 0;

  // Reference model: the set of registers owned by the MDU, plus counters.
  bit     mbusy[NREG];
  int     mpend;
  longint mscnt;
  bit     merr;
  longint m_sel;
  bit     m_stall;

  task automatic chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rs_of(int p);
    return int'(id_rs[p*AW +: AW]);
  endfunction

  function automatic void model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mpend = 0; mscnt = 0; merr = 1'b0;
  endfunction

  function automatic void model_comb();
    bit hz = 1'b0;
    m_sel = 0;
    for (int p = 0; p < NRP; p++) begin
      int r = rs_of(p);
      int sel = 0;
      if (id_rs_use[p] && r != 0) begin
        for (int s = 0; s < NSTG; s++) begin
          if (stg_wen[s] && int'(stg_rd[s*AW +: AW]) == r) begin
            sel = s + 1;
            if (stg_ld[s] && s < LD_STG) hz = 1'b1;
            break;
          end
        end
        if (mbusy[r]) hz = 1'b1;
      end
      m_sel += longint'(sel) << (p * SW);
    end
    if (id_wen && id_rd != 0 && mbusy[id_rd]) hz = 1'b1;
    if (id_mdu && mpend == MAX_PEND) hz = 1'b1;
    m_stall = id_valid && hz;
  endfunction

  function automatic void model_update();
    bit want = id_fire && id_mdu && id_wen && id_rd != 0;
    bit dok  = mdu_done && mbusy[mdu_done_rd];
    bit over = want && !m_stall && mpend == MAX_PEND && !dok;
    bit iok  = want && !m_stall && !over;
    if ((mdu_done && !dok) || (id_fire && m_stall) || over) merr = 1'b1;
    if (id_valid && m_stall && mscnt < 64'hFFFF_FFFF) mscnt++;
    if (flush) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mpend = 0;
    end else begin
      if (dok) begin mbusy[mdu_done_rd] = 1'b0; mpend--; end
      if (iok) begin mbusy[id_rd] = 1'b1; mpend++; end
    end
  endfunction

  function automatic longint busy_vec();
    longint v = 0;
    for (int i = 0; i < NREG; i++) if (mbusy[i]) v |= (longint'(1) << i);
    return v;
  endfunction

  // Called just after a rising edge with inputs already set for this cycle.
  task automatic step();
    exp_t e;
    if (!rst_n) model_reset();
    model_comb();
    e.sel = m_sel; e.stl = m_stall; e.bsy = busy_vec(); e.pend = mpend;
    e.scnt = mscnt; e.err = merr;
    expq.push_back(e);
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rs_use = '0; id_rd = '0; id_wen = 0; id_mdu = 0;
    id_fire = 0; stg_rd = '0; stg_wen = '0; stg_ld = '0; mdu_done = 0;
    mdu_done_rd = '0; flush = 0;
  endtask

  task automatic issue(int rd);
    idle(); id_valid = 1; id_mdu = 1; id_wen = 1; id_rd = AW'(rd); id_fire = 1;
    step();
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("fwd_sel",   longint'(fwd_sel),   e.sel);
        chk("stall",     longint'(stall),     e.stl);
        chk("busy",      longint'(busy),      e.bsy);
        chk("pend_cnt",  longint'(pend_cnt),  e.pend);
        chk("stall_cnt", longint'(stall_cnt), e.scnt);
        chk("sb_err",    longint'(sb_err),    e.err);
      end
    end
  end

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_n = 1;
    step();

    // Youngest writer wins.
    id_valid = 1; id_rs[0 +: AW] = 5'd5; id_rs_use = 2'b01;
    stg_wen = 3'b101; stg_rd = {5'd5, 5'd0, 5'd5};
    #1; chk("prio_sel0", longint'(fwd_sel[0 +: SW]), 1); chk("prio_stall", longint'(stall), 0);
    step();
    stg_wen = 3'b100;
    #1; chk("prio_old_sel0", longint'(fwd_sel[0 +: SW]), 3);
    step();

    // Load-use walks through stages 0,1,2.
    idle(); id_valid = 1; id_rs[AW +: AW] = 5'd7; id_rs_use = 2'b10;
    for (int s = 0; s < NSTG; s++) begin
      stg_wen = '0; stg_ld = '0; stg_rd = '0;
      stg_wen[s] = 1'b1; stg_ld[s] = 1'b1; stg_rd[s*AW +: AW] = 5'd7;
      #1; chk("lu_stall", longint'(stall), (s < LD_STG) ? 1 : 0);
      if (s == NSTG - 1) begin
        chk("lu_sel1", longint'(fwd_sel[SW +: SW]), 3);
        chk("lu_scnt", longint'(stall_cnt), 2);
      end
      step();
    end

    // MDU RAW and WAW against x9.
    issue(9);
    idle(); id_valid = 1; id_rs[0 +: AW] = 5'd9; id_rs_use = 2'b01;
    #1; chk("mdu_busy9", longint'(busy[9]), 1); chk("mdu_pend", longint'(pend_cnt), 1);
    chk("raw_stall", longint'(stall), 1);
    step();
    idle(); id_valid = 1; id_wen = 1; id_rd = 5'd9;
    #1; chk("waw_stall", longint'(stall), 1);
    step();
    mdu_done = 1; mdu_done_rd = 5'd9;
    step();
    idle(); id_valid = 1; id_rs[0 +: AW] = 5'd9; id_rs_use = 2'b01;
    #1; chk("raw_release", longint'(stall), 0);
    step();

    // Capacity and same-register issue+done.
    issue(3);
    issue(4);
    idle(); id_valid = 1; id_mdu = 1; id_wen = 1; id_rd = 5'd5;
    #1; chk("cap_stall", longint'(stall), 1); chk("cap_pend", longint'(pend_cnt), 2);
    step();
    idle(); id_fire = 1; id_mdu = 1; id_wen = 1; id_rd = 5'd3; mdu_done = 1; mdu_done_rd = 5'd3;
    step();
    idle();
    #1; chk("same_busy3", longint'(busy[3]), 1); chk("same_pend", longint'(pend_cnt), 2);
    chk("same_err", longint'(sb_err), 0);
    step();

    flush = 1;
    step();
    idle();
    #1; chk("flush_busy", longint'(busy), 0); chk("flush_pend", longint'(pend_cnt), 0);
    step();

    // x0 never matches; completion for x0 is a protocol error.
    id_valid = 1; id_rs_use = 2'b11; stg_wen = 3'b001;
    #1; chk("x0_sel", longint'(fwd_sel), 0); chk("x0_stall", longint'(stall), 0);
    step();
    idle(); mdu_done = 1; mdu_done_rd = 5'd0;
    step();
    idle();
    #1; chk("x0_err", longint'(sb_err), 1);
    step();

    // Asynchronous reset in the middle of a stall.
    issue(9);
    idle(); id_valid = 1; id_rs[0 +: AW] = 5'd9; id_rs_use = 2'b01;
    step();
    rst_n = 0;
    #1; chk("rst_busy", longint'(busy), 0); chk("rst_pend", longint'(pend_cnt), 0);
    chk("rst_scnt", longint'(stall_cnt), 0); chk("rst_err", longint'(sb_err), 0);
    chk("rst_stall", longint'(stall), 0);
    step();
    rst_n = 1;
    idle();
    step();

    // Random traffic with mostly legal handshakes.
    for (int c = 0; c < 3000; c++) begin
      idle();
      id_valid = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NRP; p++) id_rs[p*AW +: AW] = AW'($urandom_range(0, 7));
      id_rs_use = NRP'($urandom);
      id_rd  = AW'($urandom_range(0, 7));
      id_wen = $urandom_range(0, 3) != 0;
      id_mdu = $urandom_range(0, 2) == 0;
      for (int s = 0; s < NSTG; s++) stg_rd[s*AW +: AW] = AW'($urandom_range(0, 7));
      stg_wen = NSTG'($urandom);
      stg_ld  = NSTG'($urandom) & NSTG'($urandom);
      flush   = ($urandom_range(0, 49) == 0);
      if (mpend > 0 && $urandom_range(0, 2) == 0) begin
        int pick = $urandom_range(0, mpend - 1);
        for (int i = 1; i < NREG; i++) begin
          if (mbusy[i]) begin
            if (pick == 0) begin mdu_done = 1; mdu_done_rd = AW'(i); end
            pick--;
          end
        end
      end else if ($urandom_range(0, 199) == 0) begin
        mdu_done = 1; mdu_done_rd = AW'($urandom_range(0, 7));
      end
      model_comb();
      id_fire = id_valid && (!m_stall || $urandom_range(0, 299) == 0);
      if (c == 1500) begin
        rst_n = 0;
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    idle();
    repeat (3) @(negedge clk);
    n_total++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
